// File: rtl/accum_sequencer_pkg.sv
// Shared types and constants for the accumulate sequencer and its helpers.
// Opcode encodings match the external 16-bit add/subtract datapath.
package accum_sequencer_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_ADDC   = 3'b001;
  localparam logic [2:0] OP_ADDNOT = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_PASS   = 3'b100;
  localparam logic [2:0] OP_INC    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;
  localparam logic [2:0] OP_PASS1  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // B operand as the datapath sees it, before carry-in is added.
  function automatic logic [DATA_W-1:0] f_eff_b(input logic [2:0]        op,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] v;
    v = op[2] ? '0 : b;
    return op[1] ? ~v : v;
  endfunction

endpackage

// File: rtl/accum_sequencer_ovf_detect.sv
// Signed-overflow detector for A + eff_b (+cin) = Y, driven only by sign bits.
// Exact with carry-in: same-sign operands with a result sign flip means overflow.
module accum_sequencer_ovf_detect (
  input  logic i_a_sign,
  input  logic i_eff_b_sign,
  input  logic i_y_sign,
  output logic o_ovf
);

  assign o_ovf = (i_a_sign == i_eff_b_sign) && (i_y_sign != i_a_sign);

endmodule

// File: rtl/accum_sequencer.sv
// Command-driven accumulator that streams operands through the external
// add/subtract datapath and returns the final value with carry and sticky overflow.
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_init,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [DATA_W-1:0] o_dp_a,
  output logic [DATA_W-1:0] o_dp_b,
  output logic [2:0]        o_dp_opcode,
  input  logic [DATA_W-1:0] i_dp_y,
  input  logic              i_dp_co,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_co,
  output logic              o_res_ovf
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [2:0]        r_op;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_co;
  logic              r_ovf;

  logic              w_cmd_fire;
  logic              w_beat_fire;
  logic              w_last_beat;
  logic [DATA_W-1:0] w_eff_b;
  logic              w_ovf;

  assign w_cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign w_beat_fire = i_in_valid && o_in_ready;
  assign w_last_beat = (r_cnt == LEN_W'(1));
  assign w_eff_b     = f_eff_b(r_op, i_in_data);

  accum_sequencer_ovf_detect u_ovf_detect (
    .i_a_sign     (r_acc[DATA_W-1]),
    .i_eff_b_sign (w_eff_b[DATA_W-1]),
    .i_y_sign     (i_dp_y[DATA_W-1]),
    .o_ovf        (w_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt = (i_cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_beat_fire && w_last_beat) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_in_ready  = 1'b0;
    o_res_valid = 1'b0;
    o_res_data  = '0;
    o_res_co    = 1'b0;
    o_res_ovf   = 1'b0;
    case (r_state)
      IDLE: o_cmd_ready = 1'b1;
      RUN:  o_in_ready  = 1'b1;
      DONE: begin
        o_res_valid = 1'b1;
        o_res_data  = r_acc;
        o_res_co    = r_co;
        o_res_ovf   = r_ovf;
      end
      default: ;
    endcase
  end

  // Accept and beat strobes are gated by disjoint states, so at most one fires.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_op  <= '0;
      r_cnt <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_cmd_fire) begin
      r_acc <= i_cmd_init;
      r_op  <= i_cmd_op;
      r_cnt <= i_cmd_len;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_beat_fire) begin
      r_acc <= i_dp_y;
      r_co  <= i_dp_co;
      r_ovf <= r_ovf | w_ovf;
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign o_dp_a      = r_acc;
  assign o_dp_b      = i_in_data;
  assign o_dp_opcode = r_op;

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Multi-cycle controller that sits in front of the 16-bit signed add/subtract datapath and consumes its result. It accepts a command (opcode, initial value, beat count) and streams operands into the datapath one per cycle, feeding each result back as the next A operand. It returns the final 16-bit value with carry and sticky signed-overflow flags over a valid/ready result port. The datapath instance lives beside this block; this block drives its A/B/opcode and reads Y/co.

## Interface
- LEN_W, 8, width of beat counter / cmd_len
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  datapath opcode for the whole command
- cmd_init  in  16  signed initial accumulator value
- cmd_len  in  LEN_W  number of operand beats (0 allowed)
- in_valid  in  1  operand beat offered
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_data  in  16  signed operand
- dp_a  out  16  datapath A = accumulator register
- dp_b  out  16  datapath B = in_data (combinational pass-through)
- dp_opcode  out  3  latched cmd_op
- dp_y  in  16  datapath sum
- dp_co  in  1  datapath carry-out
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  16  final accumulator
- res_co  out  1  dp_co of the last accepted beat; 0 if cmd_len = 0
- res_ovf  out  1  sticky signed overflow over all beats

## Operation
- Datapath semantics, with eff_b = (op[2] ? 0 : B), inverted when op[1], plus cin = op[0]: 000 A+B, 001 A+B+1, 010 A+~B, 011 A−B, 100 A, 101 A+1, 110 A−1, 111 A.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1.
  - On accept: acc ← cmd_init, op ← cmd_op, cnt ← cmd_len, co_r ← 0, ovf_r ← 0.
  - Next state is DONE if cmd_len = 0, else RUN.
- RUN:
  - in_ready = 1.
  - On an accepted beat: acc ← dp_y, co_r ← dp_co, ovf_r ← ovf_r | ovf, cnt ← cnt − 1.
  - When cnt = 1 and a beat is accepted, go to DONE.
  - Cycles with in_valid = 0 hold all state.
- DONE:
  - res_valid = 1; res_data = acc, res_co = co_r, res_ovf = ovf_r.
  - On res_ready, go to IDLE.
  - Outputs are held stable while res_ready = 0.
- Overflow: ovf = (dp_a[15] == eff_b[15]) && (dp_y[15] != dp_a[15]). eff_b is recomputed locally from op and in_data. This rule is exact including cin (e.g. 0 − 0x8000 flags).
- Ops with op[2] = 1 ignore in_data, but each beat is still consumed and counted. This is used as per-beat increment/decrement.
- Results wrap modulo 2^16. Wrap-around is never saturated; it is only reported through res_ovf.
- cmd_len is unsigned; the maximum 2^LEN_W − 1 beats must work.
- cmd_ready and in_ready are 0 outside their states. Commands and beats offered in other states are not consumed.

## Timing
- Reset values: state IDLE; acc, op, cnt, co_r, ovf_r = 0. Hence dp_a = 0, dp_opcode = 0, res_valid = 0, res_data = 0, res_co = 0, res_ovf = 0, in_ready = 0, cmd_ready = 1.
- dp_b follows in_data combinationally. dp_y/dp_co are sampled in the same cycle, with no pipeline register inside the loop.
- Throughput: one beat per clock in RUN.
- Latency: res_valid rises in the cycle after the last beat is accepted. For cmd_len = 0 it rises in the cycle after command accept.
- Command-to-command gap: minimum 1 cycle IDLE after a DONE handshake. A command is never accepted in the same cycle as res handshake.
- rst_n = 0 mid-RUN or mid-DONE aborts the operation: the pending result is discarded and reset values apply on the next edge.

## Structure
- A shared package holds: state enum (IDLE/RUN/DONE), DATA_W = 16, and opcode constants (OP_ADD, OP_ADDC, OP_ADDNOT, OP_SUB, OP_PASS, OP_INC, OP_DEC, OP_PASS1).
- The datapath is not instantiated inside this block.
- Natural sub-module: ovf_detect (combinational; inputs a, eff_b, y; output ovf). It is reusable by other consumers of the datapath.

## Test plan
- OP_ADD, init 0x0005, len 3, beats 1, 2, 3 → res_data 0x000B, res_co 0, res_ovf 0, res_valid 1 cycle after third beat.
- OP_SUB, init 0x0000, len 1, beat 0x8000 → res_data 0x8000, res_ovf 1, res_co 0.
- OP_INC, init 0x7FFE, len 2, beats arbitrary → res_data 0x8000, res_ovf 1 (set on second beat, sticky).
- OP_ADD, len 0, init 0x1234 → res_data 0x1234, res_co 0, res_ovf 0; in_ready never asserted.
- OP_ADD, init 0, len 4, in_valid toggling every other cycle, res_ready held 0 for 3 cycles → sum correct, outputs stable until handshake, cmd_ready 0 until the cycle after the handshake.
- rst_n low for one cycle after 2 of 4 beats → all outputs at reset values. A new command is then accepted and its result is unaffected by the aborted one.
